// File: rtl/layer_seq_pkg.sv
// Shared definitions for the layer sequencer: instruction opcodes, FSM states,
// instruction field positions and layer-type encodings.
package layer_seq_pkg;

    typedef enum logic [1:0] {
        OP_FC      = 2'b00,
        OP_POOL    = 2'b01,
        OP_ILLEGAL = 2'b10,
        OP_END     = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StLaunch,
        StRun,
        StDone
    } state_e;

    // Instruction field positions
    localparam int unsigned OPCODE_MSB     = 31;
    localparam int unsigned OPCODE_LSB     = 30;
    localparam int unsigned WR_COUNT_MSB   = 15;
    localparam int unsigned WR_COUNT_LSB   = 0;
    localparam int unsigned WR_COUNT_WIDTH = WR_COUNT_MSB - WR_COUNT_LSB + 1;

    // Layer types as driven on layer_signal
    localparam logic FULLY_CONVOL = 1'b0;
    localparam logic POOLING      = 1'b1;

endpackage

// File: rtl/layer_sequencer_write_arbiter.sv
// Two-requester round-robin write arbiter with a registered output-buffer port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clr                   clears the write pointer and registered address
//   act_req, pool_req     (already qualified) write requests
//   act_data, pool_data   write data, stable while the request is high
//   act_ack, pool_ack     combinational grants, at most one per cycle
//   wr_en/wr_addr/wr_data registered write port, one cycle after the grant
module write_arbiter #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned WADDR_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   act_req,
    input  logic                   pool_req,
    input  logic [DATA_WIDTH-1:0]  act_data,
    input  logic [DATA_WIDTH-1:0]  pool_data,
    output logic                   act_ack,
    output logic                   pool_ack,
    output logic                   wr_en,
    output logic [WADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data
);

    logic                   prio_pool_q;  // 1: pooling wins the next tie
    logic [WADDR_WIDTH-1:0] ptr_q;

    always_comb begin
        act_ack  = 1'b0;
        pool_ack = 1'b0;
        if (act_req && pool_req) begin
            if (prio_pool_q) begin
                pool_ack = 1'b1;
            end else begin
                act_ack = 1'b1;
            end
        end else begin
            act_ack  = act_req;
            pool_ack = pool_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_pool_q <= 1'b0;
            ptr_q       <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            wr_en <= act_ack | pool_ack;
            if (clr) begin
                ptr_q   <= '0;
                wr_addr <= '0;
            end else if (act_ack || pool_ack) begin
                wr_data     <= act_ack ? act_data : pool_data;
                wr_addr     <= ptr_q;
                ptr_q       <= ptr_q + 1'b1;
                prio_pool_q <= act_ack;
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: fetches instructions, launches the fully-connected or pooling
// engine per instruction, funnels the engines' output writes into the output
// buffer and tracks completion of each layer.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start                          begin execution at instruction address 0
//   instr_rd/instr_addr/instr_data instruction fetch (data one cycle after rd)
//   layer_signal                   current layer (0 FULLY_CONVOL, 1 POOLING)
//   fc_start/pool_start            engine start pulses
//   fc_done/pool_done              engine completion pulses
//   act_wr_*/pool_wr_*             write request/data/ack from the two units
//   wr_en/wr_addr/wr_data          registered output-buffer write port
//   busy, done, err                running, end-of-program pulse, sticky error
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH        = 8,
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned WADDR_WIDTH       = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         instr_rd,
    output logic [ADDR_WIDTH-1:0]        instr_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_data,
    output logic                         layer_signal,
    output logic                         fc_start,
    output logic                         pool_start,
    input  logic                         fc_done,
    input  logic                         pool_done,
    input  logic                         act_wr_req,
    input  logic                         pool_wr_req,
    input  logic [DATA_WIDTH-1:0]        act_wr_data,
    input  logic [DATA_WIDTH-1:0]        pool_wr_data,
    output logic                         act_wr_ack,
    output logic                         pool_wr_ack,
    output logic                         wr_en,
    output logic [WADDR_WIDTH-1:0]       wr_addr,
    output logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     instr_addr_q, instr_addr_d;
    logic                      layer_q, layer_d;
    logic [WR_COUNT_WIDTH-1:0] wr_count_q, wr_count_d;
    logic [WR_COUNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic                      done_seen_q, done_seen_d;
    logic                      err_q, err_d;

    opcode_e opcode;
    logic    in_run, cnt_full, sel_done, other_done;
    logic    act_match, pool_match, act_qual, pool_qual, grant, clr_wr;
    logic    unused_instr;

    assign opcode       = opcode_e'(instr_data[OPCODE_MSB:OPCODE_LSB]);
    assign unused_instr = ^instr_data[OPCODE_LSB-1:WR_COUNT_MSB+1];

    assign in_run     = (state_q == StRun);
    assign cnt_full   = (wr_cnt_q == wr_count_q);
    assign sel_done   = (layer_q == POOLING) ? pool_done : fc_done;
    assign other_done = (layer_q == POOLING) ? fc_done : pool_done;
    assign act_match  = (layer_q == FULLY_CONVOL);
    assign pool_match = (layer_q == POOLING);

    // Only the unit owning the current layer may write, and only until its quota is met
    assign act_qual  = act_wr_req & in_run & act_match & ~cnt_full;
    assign pool_qual = pool_wr_req & in_run & pool_match & ~cnt_full;
    assign grant     = act_wr_ack | pool_wr_ack;

    write_arbiter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WADDR_WIDTH (WADDR_WIDTH)
    ) u_write_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_wr),
        .act_req   (act_qual),
        .pool_req  (pool_qual),
        .act_data  (act_wr_data),
        .pool_data (pool_wr_data),
        .act_ack   (act_wr_ack),
        .pool_ack  (pool_wr_ack),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always_comb begin
        state_d      = state_q;
        instr_addr_d = instr_addr_q;
        layer_d      = layer_q;
        wr_count_d   = wr_count_q;
        wr_cnt_d     = wr_cnt_q;
        done_seen_d  = done_seen_q;
        err_d        = err_q;
        clr_wr       = 1'b0;

        if (grant) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if ((state_q == StLaunch || in_run) && sel_done) begin
            done_seen_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StFetch;
                    instr_addr_d = '0;
                    err_d        = 1'b0;
                    clr_wr       = 1'b1;
                end
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                wr_cnt_d    = '0;
                done_seen_d = 1'b0;
                unique case (opcode)
                    OP_FC, OP_POOL: begin
                        layer_d    = (opcode == OP_POOL) ? POOLING : FULLY_CONVOL;
                        wr_count_d = instr_data[WR_COUNT_MSB:WR_COUNT_LSB];
                        state_d    = StLaunch;
                    end
                    OP_END: begin
                        state_d = StDone;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                endcase
            end
            StLaunch: begin
                state_d = StRun;
            end
            StRun: begin
                if ((done_seen_q || sel_done) && cnt_full) begin
                    instr_addr_d = instr_addr_q + 1'b1;
                    if (&instr_addr_q) begin
                        // Running off the end of instruction memory is a program error
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_q != StIdle && other_done) begin
            err_d = 1'b1;
        end
        // Wrong-unit request, or a request past the layer's write quota
        if (in_run && ((act_wr_req && !act_match) || (pool_wr_req && !pool_match))) begin
            err_d = 1'b1;
        end
        if (in_run && cnt_full && ((act_wr_req && act_match) || (pool_wr_req && pool_match))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            instr_addr_q <= '0;
            layer_q      <= FULLY_CONVOL;
            wr_count_q   <= '0;
            wr_cnt_q     <= '0;
            done_seen_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_addr_q <= instr_addr_d;
            layer_q      <= layer_d;
            wr_count_q   <= wr_count_d;
            wr_cnt_q     <= wr_cnt_d;
            done_seen_q  <= done_seen_d;
            err_q        <= err_d;
        end
    end

    assign instr_rd     = (state_q == StFetch);
    assign instr_addr   = instr_addr_q;
    assign layer_signal = layer_q;
    assign fc_start     = (state_q == StLaunch) && (layer_q == FULLY_CONVOL);
    assign pool_start   = (state_q == StLaunch) && (layer_q == POOLING);
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign err          = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

    localparam int IW  = 32;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int WAW = 12;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           instr_rd;
    logic [AW-1:0]  instr_addr;
    logic [IW-1:0]  instr_data = '0;
    logic           layer_signal, fc_start, pool_start;
    logic           fc_done = 1'b0, pool_done = 1'b0;
    logic           act_wr_req = 1'b0, pool_wr_req = 1'b0;
    logic [DW-1:0]  act_wr_data = '0, pool_wr_data = '0;
    logic           act_wr_ack, pool_wr_ack, wr_en;
    logic [WAW-1:0] wr_addr;
    logic [DW-1:0]  wr_data;
    logic           busy, done, err;

    always #5 clk = ~clk;

    layer_sequencer #(
        .INSTRUCTION_WIDTH (IW),
        .ADDR_WIDTH        (AW),
        .DATA_WIDTH        (DW),
        .WADDR_WIDTH       (WAW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .instr_rd     (instr_rd),
        .instr_addr   (instr_addr),
        .instr_data   (instr_data),
        .layer_signal (layer_signal),
        .fc_start     (fc_start),
        .pool_start   (pool_start),
        .fc_done      (fc_done),
        .pool_done    (pool_done),
        .act_wr_req   (act_wr_req),
        .pool_wr_req  (pool_wr_req),
        .act_wr_data  (act_wr_data),
        .pool_wr_data (pool_wr_data),
        .act_wr_ack   (act_wr_ack),
        .pool_wr_ack  (pool_wr_ack),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // Instruction memory: word appears one cycle after the read strobe
    logic [IW-1:0] imem [0:255];
    always @(posedge clk) begin
        if (instr_rd) instr_data <= imem[instr_addr];
    end

    // Program description: 0 = FC, 1 = POOL, 2 = illegal, 3 = END
    int prog_op  [0:255];
    int prog_cnt [0:255];

    int vectors = 0;
    int miscompares = 0;
    int model_waddr = 0;

    typedef struct {
        logic [WAW-1:0] addr;
        logic [DW-1:0]  data;
    } wr_t;
    wr_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output-buffer write must match the oldest expected one
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            prog_op[i]  = 3;
            prog_cnt[i] = 0;
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d);
        wr_t e;
        e.addr = WAW'(model_waddr);
        e.data = d;
        exp_q.push_back(e);
        model_waddr++;
    endtask

    // Called at a negedge; returns at the negedge after the write was granted
    task automatic do_write(input bit pool, input logic [DW-1:0] d);
        int t;
        push_exp(d);
        if (pool) begin
            pool_wr_req  = 1'b1;
            pool_wr_data = d;
        end else begin
            act_wr_req  = 1'b1;
            act_wr_data = d;
        end
        t = 0;
        #1;
        while (!(pool ? pool_wr_ack : act_wr_ack)) begin
            @(negedge clk);
            #1;
            t++;
            if (t > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL ack_timeout: got no ack in 50 cycles, expected an ack");
                break;
            end
        end
        @(negedge clk);
        act_wr_req  = 1'b0;
        pool_wr_req = 1'b0;
    endtask

    task automatic pulse_done(input bit pool);
        if (pool) pool_done = 1'b1;
        else fc_done = 1'b1;
        @(negedge clk);
        fc_done   = 1'b0;
        pool_done = 1'b0;
    endtask

    // Engine behaviour for one layer. dmode: 0 random done position, 1 done last, 2 done first
    task automatic engine(input bit pool, input int cnt, input int dmode);
        int dpos;
        dpos = (dmode == 1) ? cnt : (dmode == 2) ? 0 : int'($urandom_range(cnt, 0));
        @(negedge clk);
        if ($urandom_range(3, 0) == 0) begin
            start = 1'b1;  // must be ignored while busy
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i <= cnt; i++) begin
            if (i == dpos) pulse_done(pool);
            if (i < cnt) begin
                repeat ($urandom_range(2, 0)) @(negedge clk);
                do_write(pool, DW'($urandom));
            end
        end
    endtask

    // Both units request in two RUN cycles while the layer is FULLY_CONVOL
    task automatic mismatch_engine();
        logic [DW-1:0] d;
        @(negedge clk);
        d = DW'($urandom);
        push_exp(d);
        act_wr_req   = 1'b1;
        act_wr_data  = d;
        pool_wr_req  = 1'b1;
        pool_wr_data = DW'($urandom);
        #1;
        check("mm_act_ack1", 64'(act_wr_ack), 64'd1);
        check("mm_pool_ack1", 64'(pool_wr_ack), 64'd0);
        @(negedge clk);
        d = DW'($urandom);
        push_exp(d);
        act_wr_data = d;
        #1;
        check("mm_act_ack2", 64'(act_wr_ack), 64'd1);
        check("mm_pool_ack2", 64'(pool_wr_ack), 64'd0);
        @(negedge clk);
        act_wr_req = 1'b0;
        #1;
        check("mm_err", 64'(err), 64'd1);
        check("mm_pool_refused", 64'(pool_wr_ack), 64'd0);
        @(negedge clk);
        pool_wr_req = 1'b0;
        pulse_done(1'b0);
    endtask

    // mode: 0 normal, 1 mismatch injection on first layer, 2 reset after first write
    task automatic run_program(input int mode, input int dmode);
        int  pc, cyc, nfc, npool, exp_fc, exp_pool;
        bit  exp_err, first, is_pool;
        logic [2:0] exp_kind;
        exp_fc = 0;
        exp_pool = 0;
        exp_err = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (prog_op[i] == 0) exp_fc++;
            else if (prog_op[i] == 1) exp_pool++;
            else begin
                exp_err = (prog_op[i] == 2);
                break;
            end
        end
        if (mode == 1) exp_err = 1'b1;
        for (int i = 0; i < 256; i++) begin
            imem[i] = {prog_op[i][1:0], 14'b0, prog_cnt[i][15:0]};
        end
        model_waddr = 0;
        exp_q.delete();
        pc = 0;
        nfc = 0;
        npool = 0;
        first = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        forever begin
            if (cyc > 3000) begin
                vectors++;
                miscompares++;
                $display("FAIL prog_timeout: got no done pulse in 3000 cycles, expected one");
                break;
            end
            if (instr_rd) check("instr_addr", 64'(instr_addr), 64'(pc));
            if (fc_start || pool_start) begin
                is_pool = pool_start;
                if (first) check("start_latency", 64'(cyc), 64'd3);
                first = 1'b0;
                exp_kind = (prog_op[pc] == 0) ? 3'b100 : (prog_op[pc] == 1) ? 3'b011 : 3'b000;
                check("layer_kind", 64'({fc_start, pool_start, layer_signal}), 64'(exp_kind));
                if (is_pool) npool++;
                else nfc++;
                if (mode == 2) begin
                    @(negedge clk);
                    do_write(1'b0, DW'($urandom));
                    #2 rst_n = 1'b0;
                    #1;
                    check("reset_outputs",
                          64'({busy, done, err, wr_en, instr_rd, fc_start, pool_start,
                               act_wr_ack, pool_wr_ack, layer_signal, instr_addr, wr_addr}),
                          64'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    check("reset_sb_drained", 64'(exp_q.size()), 64'd0);
                    exp_q.delete();
                    return;
                end
                if (mode == 1 && pc == 0) mismatch_engine();
                else engine(is_pool, prog_cnt[pc], dmode);
                pc++;
                cyc += 10;
                continue;
            end
            if (done) break;
            @(negedge clk);
            cyc++;
        end
        check("prog_err", 64'(err), 64'(exp_err));
        check("fc_starts", 64'(nfc), 64'(exp_fc));
        check("pool_starts", 64'(npool), 64'(exp_pool));
        @(negedge clk);
        check("idle_after_done", 64'({busy, done}), 64'd0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        clear_prog();
        repeat (3) @(negedge clk);
        check("reset_state",
              64'({busy, done, err, wr_en, instr_rd, fc_start, pool_start,
                   act_wr_ack, pool_wr_ack, layer_signal, instr_addr, wr_addr}),
              64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // FC x3 then END
        clear_prog();
        prog_op[0] = 0; prog_cnt[0] = 3;
        run_program(0, 0);

        // FC x2, POOL x2 with pool_done after the quota, END
        clear_prog();
        prog_op[0] = 0; prog_cnt[0] = 2;
        prog_op[1] = 1; prog_cnt[1] = 2;
        run_program(0, 1);

        // Wrong-unit requests during an FC layer
        clear_prog();
        prog_op[0] = 0; prog_cnt[0] = 2;
        run_program(1, 0);

        // Illegal opcode at address 1; FC at address 2 must never start
        clear_prog();
        prog_op[0] = 0; prog_cnt[0] = 1;
        prog_op[1] = 2;
        prog_op[2] = 0; prog_cnt[2] = 1;
        run_program(0, 2);

        // Reset mid-RUN after one write, then a clean rerun
        clear_prog();
        prog_op[0] = 0; prog_cnt[0] = 3;
        run_program(2, 0);
        run_program(0, 0);

        // FC with zero writes
        clear_prog();
        prog_op[0] = 0; prog_cnt[0] = 0;
        run_program(0, 0);

        // Random programs
        for (int p = 0; p < 20; p++) begin
            int len;
            clear_prog();
            len = int'($urandom_range(4, 1));
            for (int i = 0; i < len; i++) begin
                prog_op[i]  = int'($urandom_range(1, 0));
                prog_cnt[i] = int'($urandom_range(4, 0));
            end
            run_program(0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
